// File: rtl/tanimoto_hit_collector_pkg.sv
// ---------------------------------------------------------------------------
// tanimoto_hit_collector_pkg
// Shared constants for the hit collector and its neighbours in the
// comparator/popcount pipeline: default ID widths, the packed pair-ID width,
// and the saturating increment used by the hit counter.
// ---------------------------------------------------------------------------
package tanimoto_hit_collector_pkg;

  localparam int DEF_REF_ID_WIDTH = 16;
  localparam int DEF_QRY_ID_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH   = 32;

  // Pair ID is {qry_id, ref_id}; the query ID occupies the upper bits.
  localparam int PAIR_ID_WIDTH = DEF_QRY_ID_WIDTH + DEF_REF_ID_WIDTH;

  localparam logic [31:0] HIT_CNT_MAX = 32'hFFFF_FFFF;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == HIT_CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tanimoto_hit_collector_if.sv
// ---------------------------------------------------------------------------
// tanimoto_hit_collector_if
// Hit-ID stream from the collector to the host-side DMA/stream sink.
//
// Handshake: a beat transfers on a clock edge where valid & ready are both 1.
// The master never waits for ready before raising valid, and once valid is
// high it holds valid and data unchanged until the beat transfers. The slave
// may raise or drop ready at any time; ready while valid is low has no effect.
//
//   data   master->slave  DATA_W  {qry_id, ref_id} of the current beat
//   valid  master->slave  1       data holds a beat
//   ready  slave->master  1       slave takes the beat on this edge
// ---------------------------------------------------------------------------
interface tanimoto_hit_collector_if #(
  parameter int DATA_W = tanimoto_hit_collector_pkg::PAIR_ID_WIDTH
) ();

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/tanimoto_hit_collector_hit_fifo.sv
// ---------------------------------------------------------------------------
// hit_fifo
// Synchronous first-word-fall-through FIFO: the head entry is on dout
// whenever empty is low, with no read latency. A push accepted in cycle N is
// on dout in cycle N+1 when the FIFO was empty.
//
//   clk, rst  clock, asynchronous active-high reset
//   flush     synchronous: drop all entries (pointers back to zero)
//   push/din  write request; accepted when not full, or when full with pop
//   pop       remove head; ignored while empty
//   dout      head entry (stale last value while empty)
//   full      DEPTH entries held
//   empty     no entries held
// ---------------------------------------------------------------------------
module hit_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when addresses match.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // When full, the slot being written is the one being popped this cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/tanimoto_hit_collector.sv
// ---------------------------------------------------------------------------
// tanimoto_hit_collector
// Follows the comparator's per-pair hit strobes, tracks the (query, ref)
// pair each strobe belongs to (ref is the fast index), buffers hit IDs in a
// FWFT FIFO and streams them out over a valid/ready interface.
//
//   clk         clock
//   rst         asynchronous active-high reset
//   i_Clear     sync start-of-job clear; latches i_RefCount/i_QryCount
//   i_RefCount  references per query
//   i_QryCount  queries in the job
//   i_Hit       comparator hit bit for the strobed pair
//   i_Valid     comparator strobe, one pair per cycle
//   out_if      hit-ID stream (data = {qry_id, ref_id})
//   o_HitCnt    hits accepted into the FIFO since clear (saturating)
//   o_Overflow  sticky: a hit was dropped because the FIFO was full
//   o_Done      all pairs seen and FIFO drained
// ---------------------------------------------------------------------------
module tanimoto_hit_collector
  import tanimoto_hit_collector_pkg::*;
#(
  parameter int REF_ID_WIDTH = DEF_REF_ID_WIDTH,
  parameter int QRY_ID_WIDTH = DEF_QRY_ID_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  localparam int FIFO_AW     = $clog2(FIFO_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_Clear,
  input  logic [REF_ID_WIDTH-1:0]  i_RefCount,
  input  logic [QRY_ID_WIDTH-1:0]  i_QryCount,
  input  logic                     i_Hit,
  input  logic                     i_Valid,
  tanimoto_hit_collector_if.master out_if,
  output logic [31:0]              o_HitCnt,
  output logic                     o_Overflow,
  output logic                     o_Done
);

  localparam int PAIR_W = QRY_ID_WIDTH + REF_ID_WIDTH;

  logic [REF_ID_WIDTH-1:0] ref_idx_q, ref_idx_d, ref_total_q;
  logic [QRY_ID_WIDTH-1:0] qry_idx_q, qry_idx_d, qry_total_q;
  logic [31:0]             hit_cnt_q, hit_cnt_d;
  logic                    ovf_q, ovf_d;

  logic              job_done;
  logic              strobe;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PAIR_W-1:0] fifo_dout;

  // A zero reference count means there are no pairs at all, even though the
  // query index never reaches a non-zero query count.
  assign job_done = (qry_idx_q == qry_total_q) || (ref_total_q == '0);

  // Clear wins over a strobe in the same cycle.
  assign strobe   = i_Valid & ~job_done & ~i_Clear;
  assign push_req = strobe & i_Hit;
  assign pop      = ~fifo_empty & out_if.ready & ~i_Clear;
  assign push_ok  = push_req & (~fifo_full | pop);

  always_comb begin
    ref_idx_d = ref_idx_q;
    qry_idx_d = qry_idx_q;
    hit_cnt_d = hit_cnt_q;
    ovf_d     = ovf_q;
    // Pair counters advance on every accepted strobe, hit or not, and even
    // when the hit is dropped.
    if (strobe) begin
      if (ref_idx_q == ref_total_q - REF_ID_WIDTH'(1)) begin
        ref_idx_d = '0;
        qry_idx_d = qry_idx_q + QRY_ID_WIDTH'(1);
      end else begin
        ref_idx_d = ref_idx_q + REF_ID_WIDTH'(1);
      end
    end
    if (push_ok) hit_cnt_d = sat_inc32(hit_cnt_q);
    if (push_req && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_idx_q   <= '0;
      qry_idx_q   <= '0;
      ref_total_q <= '0;
      qry_total_q <= '0;
      hit_cnt_q   <= '0;
      ovf_q       <= 1'b0;
    end else if (i_Clear) begin
      ref_idx_q   <= '0;
      qry_idx_q   <= '0;
      ref_total_q <= i_RefCount;
      qry_total_q <= i_QryCount;
      hit_cnt_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      ref_idx_q   <= ref_idx_d;
      qry_idx_q   <= qry_idx_d;
      hit_cnt_q   <= hit_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  hit_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_hit_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (i_Clear),
    .push  (push_ok),
    .din   ({qry_idx_q, ref_idx_q}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_if.data  = fifo_dout;
  assign out_if.valid = ~fifo_empty;
  assign o_HitCnt     = hit_cnt_q;
  assign o_Overflow   = ovf_q;
  // Built only from registered state; no path from i_Valid or ready.
  assign o_Done       = job_done & fifo_empty;

endmodule

// File: tb/tb_tanimoto_hit_collector.sv
// ---------------------------------------------------------------------------
// tb_tanimoto_hit_collector
// Directed bench for tanimoto_hit_collector with a 4-entry FIFO.
// ---------------------------------------------------------------------------
module tb_tanimoto_hit_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_Clear;
  logic [15:0] i_RefCount;
  logic [15:0] i_QryCount;
  logic        i_Hit;
  logic        i_Valid;
  logic [31:0] o_HitCnt;
  logic        o_Overflow;
  logic        o_Done;

  tanimoto_hit_collector_if #(.DATA_W(32)) bus ();

  tanimoto_hit_collector #(
    .REF_ID_WIDTH (16),
    .QRY_ID_WIDTH (16),
    .FIFO_DEPTH   (4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_Clear    (i_Clear),
    .i_RefCount (i_RefCount),
    .i_QryCount (i_QryCount),
    .i_Hit      (i_Hit),
    .i_Valid    (i_Valid),
    .out_if     (bus),
    .o_HitCnt   (o_HitCnt),
    .o_Overflow (o_Overflow),
    .o_Done     (o_Done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] pid(input int q, input int r);
    return {q[15:0], r[15:0]};
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_job(input int refs, input int qrys);
    i_Clear    = 1'b1;
    i_RefCount = refs[15:0];
    i_QryCount = qrys[15:0];
    tick();
    i_Clear    = 1'b0;
  endtask

  task automatic pair(input logic hit);
    i_Valid = 1'b1;
    i_Hit   = hit;
    tick();
    i_Valid = 1'b0;
    i_Hit   = 1'b0;
  endtask

  // Pop everything in exp_q with ready held high, checking order.
  task automatic drain(input string tag);
    int guard;
    guard     = 0;
    bus.ready = 1'b1;
    while (exp_q.size() > 0 && guard < 20) begin
      check1({tag, "_valid"}, bus.valid, 1'b1);
      check32({tag, "_data"}, bus.data, exp_q.pop_front());
      tick();
      guard++;
    end
    bus.ready = 1'b0;
    check1({tag, "_empty"}, bus.valid, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          received;
    logic        prev_stall;
    logic [31:0] prev_data;

    rst        = 1'b1;
    i_Clear    = 1'b0;
    i_RefCount = '0;
    i_QryCount = '0;
    i_Hit      = 1'b0;
    i_Valid    = 1'b0;
    bus.ready  = 1'b0;
    tick();
    tick();

    // Reset state: zero-pair job with empty FIFO counts as done.
    check1 ("rst_valid", bus.valid, 1'b0);
    check32("rst_data",  bus.data,  32'h0);
    check32("rst_hitcnt", o_HitCnt, 32'h0);
    check1 ("rst_ovf",   o_Overflow, 1'b0);
    check1 ("rst_done",  o_Done,    1'b1);
    rst = 1'b0;
    tick();

    // 3 refs x 2 queries, hits on pairs 1 and 4, sink always ready.
    clear_job(3, 2);
    check1("t2_done_start", o_Done, 1'b0);
    bus.ready = 1'b1;
    for (int p = 0; p < 6; p++) begin
      pair(p == 1 || p == 4);
      if (p == 1) begin
        check1 ("t2_valid_p1", bus.valid, 1'b1);
        check32("t2_data_p1",  bus.data,  pid(0, 1));
      end
      if (p == 2) check1("t2_popped_p1", bus.valid, 1'b0);
      if (p == 4) begin
        check32("t2_data_p4", bus.data, pid(1, 1));
        check1 ("t2_notdone_p4", o_Done, 1'b0);
      end
    end
    check1 ("t2_valid_end", bus.valid, 1'b0);
    check32("t2_hitcnt",   o_HitCnt,  32'd2);
    check1 ("t2_done",     o_Done,    1'b1);
    pair(1'b1);
    check1 ("t2_post_valid", bus.valid, 1'b0);
    check32("t2_post_hitcnt", o_HitCnt, 32'd2);
    check1 ("t2_post_done",  o_Done,   1'b1);
    bus.ready = 1'b0;

    // Six hits into a 4-entry FIFO with no drain.
    clear_job(8, 1);
    for (int p = 0; p < 4; p++) pair(1'b1);
    check1("t3_ovf_at_full", o_Overflow, 1'b0);
    pair(1'b1);
    pair(1'b1);
    check32("t3_hitcnt", o_HitCnt,   32'd4);
    check1 ("t3_ovf",    o_Overflow, 1'b1);
    for (int r = 0; r < 4; r++) exp_q.push_back(pid(0, r));
    drain("t3_drain");
    check1("t3_ovf_sticky", o_Overflow, 1'b1);
    check1("t3_notdone",    o_Done,     1'b0);

    // Full FIFO plus a hit in the same cycle as a pop.
    clear_job(8, 1);
    check1("t4_ovf_cleared", o_Overflow, 1'b0);
    for (int p = 0; p < 4; p++) pair(1'b1);
    bus.ready = 1'b1;
    pair(1'b1);
    bus.ready = 1'b0;
    check1 ("t4_ovf",    o_Overflow, 1'b0);
    check32("t4_hitcnt", o_HitCnt,   32'd5);
    for (int r = 1; r < 5; r++) exp_q.push_back(pid(0, r));
    drain("t4_drain");

    // Backpressure: ready toggles every cycle, hits on even pairs.
    clear_job(20, 1);
    for (int r = 0; r < 20; r += 2) exp_q.push_back(pid(0, r));
    received   = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 80 && received < 10; cyc++) begin
      bus.ready = (cyc % 2 == 0);
      i_Valid   = (cyc < 20);
      i_Hit     = (cyc < 20) && (cyc % 2 == 0);
      if (prev_stall) check32("t5_stable", bus.data, prev_data);
      if (bus.valid && bus.ready) begin
        check32("t5_order", bus.data, exp_q.pop_front());
        received++;
      end
      prev_stall = bus.valid & ~bus.ready;
      prev_data  = bus.data;
      tick();
    end
    i_Valid   = 1'b0;
    i_Hit     = 1'b0;
    bus.ready = 1'b0;
    check32("t5_received", 32'(received), 32'd10);
    check32("t5_hitcnt",   o_HitCnt,     32'd10);
    check1 ("t5_ovf",      o_Overflow,   1'b0);
    check1 ("t5_done",     o_Done,       1'b1);
    exp_q.delete();

    // Clear with a hit strobe in the same cycle: the strobe is ignored.
    i_Clear    = 1'b1;
    i_RefCount = 16'd2;
    i_QryCount = 16'd1;
    i_Valid    = 1'b1;
    i_Hit      = 1'b1;
    tick();
    i_Clear = 1'b0;
    i_Valid = 1'b0;
    i_Hit   = 1'b0;
    check1 ("t6_valid",  bus.valid, 1'b0);
    check32("t6_hitcnt", o_HitCnt,  32'd0);
    check1 ("t6_done",   o_Done,    1'b0);
    pair(1'b1);
    check32("t6_first_id", bus.data, pid(0, 0));
    pair(1'b0);
    check1("t6_done_wait_drain", o_Done, 1'b0);
    exp_q.push_back(pid(0, 0));
    drain("t6_drain");
    check1("t6_done_after_drain", o_Done, 1'b1);
    pair(1'b1);
    pair(1'b1);
    check1 ("t6_extra_valid",  bus.valid, 1'b0);
    check32("t6_extra_hitcnt", o_HitCnt,  32'd1);
    check1 ("t6_extra_done",   o_Done,    1'b1);

    // Zero reference count: done straight after clear, strobes ignored.
    clear_job(0, 5);
    check1("t6_zero_ref_done", o_Done, 1'b1);
    pair(1'b1);
    check32("t6_zero_ref_hitcnt", o_HitCnt, 32'd0);
    check1 ("t6_zero_ref_valid",  bus.valid, 1'b0);

    // Asynchronous reset in the middle of an overflowed job.
    clear_job(4, 2);
    for (int p = 0; p < 6; p++) pair(1'b1);
    check1 ("t1_ovf_before",    o_Overflow, 1'b1);
    check32("t1_hitcnt_before", o_HitCnt,   32'd4);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check1 ("t1_valid",  bus.valid,  1'b0);
    check32("t1_data",   bus.data,   32'h0);
    check32("t1_hitcnt", o_HitCnt,   32'h0);
    check1 ("t1_ovf",    o_Overflow, 1'b0);
    check1 ("t1_done",   o_Done,     1'b1);
    tick();
    rst = 1'b0;
    tick();
    check1("t1_done_after_release", o_Done, 1'b1);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
